// File: rtl/or_prefix_pipe_if.sv
// Request/result bundle for or_prefix_pipe. The master drives vectors and
// control; the slave (the pipe) returns the prefix result and sticky flag.
interface or_prefix_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         stall;
  logic         clr;
  logic         out_valid;
  logic [N-1:0] out_prefix;
  logic         out_any;
  logic         acc_any;

  modport master (
    output in_valid, in_data, stall, clr,
    input  out_valid, out_prefix, out_any, acc_any
  );

  modport slave (
    input  in_valid, in_data, stall, clr,
    output out_valid, out_prefix, out_any, acc_any
  );
endinterface

// File: rtl/or_prefix_pipe.sv
// Pipelined prefix-OR: stage s resolves bit group s-1 of an N-bit vector,
// unresolved groups ride along raw, plus a sticky "any result set" flag.

// One pipeline stage: chains group IDX onto the carry from the group below.
module or_prefix_stage #(
  parameter int N   = 8,
  parameter int G   = 2,
  parameter int IDX = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  localparam int LO = IDX * G;
  localparam int HI = (LO + G - 1 < N - 1) ? LO + G - 1 : N - 1;

  logic         cin;
  logic         carry;
  logic [N-1:0] nxt;

  // The bit just below this group is already a resolved prefix bit.
  if (IDX == 0) begin : g_cin0
    assign cin = 1'b0;
  end else begin : g_cin
    assign cin = d[LO-1];
  end

  always_comb begin
    nxt   = d;
    carry = cin;
    for (int k = LO; k <= HI; k++) begin
      carry  = carry | d[k];
      nxt[k] = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (!stall) q <= nxt;
  end
endmodule

module or_prefix_pipe #(
  parameter int N = 8,
  parameter int G = 2
) (
  input  logic           clk,
  input  logic           rst,
  or_prefix_pipe_if.slave bus
);
  localparam int S = (N + G - 1) / G;

  logic [N-1:0] stg [0:S];
  logic [S:1]   vld_q;
  logic [S:0]   vld_pipe;
  logic         load;
  logic         new_any;
  logic         acc_q;

  assign stg[0]   = bus.in_data;
  assign vld_pipe = {vld_q, bus.in_valid};

  for (genvar s = 0; s < S; s++) begin : g_stage
    or_prefix_stage #(.N(N), .G(G), .IDX(s)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .stall (bus.stall),
      .d     (stg[s]),
      .q     (stg[s+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)             vld_q <= '0;
    else if (!bus.stall) vld_q <= vld_pipe[S-1:0];
  end

  // Entering the last stage, the low bits are prefixes and the rest raw,
  // so the OR of the whole word is the final out_any about to load.
  assign load    = !bus.stall && vld_pipe[S-1];
  assign new_any = |stg[S-1];

  always_ff @(posedge clk) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= (bus.clr ? 1'b0 : acc_q) | (load & new_any);
  end

  assign bus.out_valid  = vld_pipe[S];
  assign bus.out_prefix = stg[S];
  assign bus.out_any    = stg[S][N-1];
  assign bus.acc_any    = acc_q;
endmodule

// File: tb/tb_or_prefix_pipe.sv
// Directed and random checks of or_prefix_pipe over several N/G shapes.
module tb_or_prefix_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] seen;

  always #5 clk = ~clk;

  or_prefix_pipe_if #(.N(8))  m_if ();
  or_prefix_pipe_if #(.N(1))  a1_if ();
  or_prefix_pipe_if #(.N(4))  a4_if ();
  or_prefix_pipe_if #(.N(5))  a5_if ();
  or_prefix_pipe_if #(.N(5))  a5n_if ();
  or_prefix_pipe_if #(.N(33)) a33_if ();
  or_prefix_pipe_if #(.N(33)) a33g_if ();
  or_prefix_pipe_if #(.N(33)) a33n_if ();

  or_prefix_pipe #(.N(8),  .G(2))  u_m    (.clk(clk), .rst(rst), .bus(m_if.slave));
  or_prefix_pipe #(.N(1),  .G(1))  u_a1   (.clk(clk), .rst(rst), .bus(a1_if.slave));
  or_prefix_pipe #(.N(4),  .G(1))  u_a4   (.clk(clk), .rst(rst), .bus(a4_if.slave));
  or_prefix_pipe #(.N(5),  .G(2))  u_a5   (.clk(clk), .rst(rst), .bus(a5_if.slave));
  or_prefix_pipe #(.N(5),  .G(5))  u_a5n  (.clk(clk), .rst(rst), .bus(a5n_if.slave));
  or_prefix_pipe #(.N(33), .G(2))  u_a33  (.clk(clk), .rst(rst), .bus(a33_if.slave));
  or_prefix_pipe #(.N(33), .G(1))  u_a33g (.clk(clk), .rst(rst), .bus(a33g_if.slave));
  or_prefix_pipe #(.N(33), .G(33)) u_a33n (.clk(clk), .rst(rst), .bus(a33n_if.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pfx(input logic [63:0] v, input int n);
    logic [63:0] r;
    logic a;
    r = '0;
    a = 1'b0;
    for (int k = 0; k < n; k++) begin
      a    = a | v[k];
      r[k] = a;
    end
    return r;
  endfunction

  task automatic aux_drive(input logic [63:0] v, input logic vld);
    a1_if.in_data   = v[0:0];  a1_if.in_valid   = vld;
    a4_if.in_data   = v[3:0];  a4_if.in_valid   = vld;
    a5_if.in_data   = v[4:0];  a5_if.in_valid   = vld;
    a5n_if.in_data  = v[4:0];  a5n_if.in_valid  = vld;
    a33_if.in_data  = v[32:0]; a33_if.in_valid  = vld;
    a33g_if.in_data = v[32:0]; a33g_if.in_valid = vld;
    a33n_if.in_data = v[32:0]; a33n_if.in_valid = vld;
  endtask

  // One pulse was offered c edges ago; a lane of latency s reports only at c==s.
  task automatic check_lane(input string tag, input int s, input int n, input int c,
                            input logic ov, input logic [63:0] op, input logic oa,
                            input logic acc, input logic [63:0] v);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    if (c == s) begin
      chk({tag, ".valid"},  {63'd0, ov},  64'd1);
      chk({tag, ".prefix"}, op,           pfx(v, n));
      chk({tag, ".any"},    {63'd0, oa},  {63'd0, |(v & m)});
      chk({tag, ".acc"},    {63'd0, acc}, {63'd0, |(seen & m)});
    end else begin
      chk({tag, ".idle"}, {63'd0, ov}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] v;
    rst = 1'b1;
    seen = '0;
    m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.stall = 1'b0; m_if.clr = 1'b0;
    a1_if.stall = 0;   a1_if.clr = 0;   a4_if.stall = 0;   a4_if.clr = 0;
    a5_if.stall = 0;   a5_if.clr = 0;   a5n_if.stall = 0;  a5n_if.clr = 0;
    a33_if.stall = 0;  a33_if.clr = 0;  a33g_if.stall = 0; a33g_if.clr = 0;
    a33n_if.stall = 0; a33n_if.clr = 0;
    aux_drive(64'd0, 1'b0);
    tick(); tick();

    chk("rst.valid",  {63'd0, m_if.out_valid}, 64'd0);
    chk("rst.prefix", {56'd0, m_if.out_prefix}, 64'd0);
    chk("rst.any",    {63'd0, m_if.out_any}, 64'd0);
    chk("rst.acc",    {63'd0, m_if.acc_any}, 64'd0);
    chk("rst.a4",     {60'd0, a4_if.out_prefix}, 64'd0);
    rst = 1'b0;

    // N=4 G=1: 0100 -> 1100 after four edges
    seen = seen | 64'h4;
    aux_drive(64'h4, 1'b1); tick();
    aux_drive(64'h4, 1'b0); tick(); tick();
    chk("a4.early", {63'd0, a4_if.out_valid}, 64'd0);
    tick();
    chk("a4.valid",  {63'd0, a4_if.out_valid}, 64'd1);
    chk("a4.prefix", {60'd0, a4_if.out_prefix}, 64'hC);
    chk("a4.any",    {63'd0, a4_if.out_any}, 64'd1);
    chk("a4.acc",    {63'd0, a4_if.acc_any}, 64'd1);

    // N=5 G=2: uneven last group, 10000 -> 10000 after three edges
    seen = seen | 64'h10;
    aux_drive(64'h10, 1'b1); tick();
    aux_drive(64'h10, 1'b0); tick(); tick();
    chk("a5.valid",  {63'd0, a5_if.out_valid}, 64'd1);
    chk("a5.prefix", {59'd0, a5_if.out_prefix}, 64'h10);
    repeat (40) tick();

    // Single-pulse random sweep over all shapes
    for (int t = 0; t < 12; t++) begin
      v = {$urandom, $urandom};
      if (t == 0) v = 64'h1_0000_0000;
      if (t == 1) v = 64'd0;
      seen = seen | v;
      aux_drive(v, 1'b1);
      for (int c = 1; c <= 33; c++) begin
        tick();
        if (c == 1) aux_drive(v, 1'b0);
        check_lane("a1",   1,  1,  c, a1_if.out_valid,   a1_if.out_prefix,   a1_if.out_any,   a1_if.acc_any,   v);
        check_lane("a4",   4,  4,  c, a4_if.out_valid,   a4_if.out_prefix,   a4_if.out_any,   a4_if.acc_any,   v);
        check_lane("a5",   3,  5,  c, a5_if.out_valid,   a5_if.out_prefix,   a5_if.out_any,   a5_if.acc_any,   v);
        check_lane("a5n",  1,  5,  c, a5n_if.out_valid,  a5n_if.out_prefix,  a5n_if.out_any,  a5n_if.acc_any,  v);
        check_lane("a33",  17, 33, c, a33_if.out_valid,  a33_if.out_prefix,  a33_if.out_any,  a33_if.acc_any,  v);
        check_lane("a33g", 33, 33, c, a33g_if.out_valid, a33g_if.out_prefix, a33g_if.out_any, a33g_if.acc_any, v);
        check_lane("a33n", 1,  33, c, a33n_if.out_valid, a33n_if.out_prefix, a33n_if.out_any, a33n_if.acc_any, v);
      end
    end

    // N=8 G=2: back-to-back 10, 00, 81
    m_if.in_valid = 1'b1; m_if.in_data = 8'h10; tick();
    m_if.in_data = 8'h00; tick();
    m_if.in_data = 8'h81; tick();
    chk("b2b.acc0", {63'd0, m_if.acc_any}, 64'd0);
    m_if.in_valid = 1'b0; tick();
    chk("b2b.v0", {63'd0, m_if.out_valid}, 64'd1);
    chk("b2b.p0", {56'd0, m_if.out_prefix}, 64'hF0);
    chk("b2b.acc1", {63'd0, m_if.acc_any}, 64'd1);
    tick();
    chk("b2b.v1", {63'd0, m_if.out_valid}, 64'd1);
    chk("b2b.p1", {56'd0, m_if.out_prefix}, 64'h00);
    chk("b2b.any1", {63'd0, m_if.out_any}, 64'd0);
    chk("b2b.acc2", {63'd0, m_if.acc_any}, 64'd1);
    tick();
    chk("b2b.v2", {63'd0, m_if.out_valid}, 64'd1);
    chk("b2b.p2", {56'd0, m_if.out_prefix}, 64'hFF);
    tick();
    chk("b2b.end", {63'd0, m_if.out_valid}, 64'd0);

    // Stall three cycles after two; offered inputs during stall are dropped
    m_if.in_valid = 1'b1; m_if.in_data = 8'h01; tick();
    m_if.in_valid = 1'b0; tick();
    m_if.stall = 1'b1; m_if.in_valid = 1'b1; m_if.in_data = 8'h80; tick();
    chk("stall.v3", {63'd0, m_if.out_valid}, 64'd0);
    tick(); tick();
    chk("stall.v5", {63'd0, m_if.out_valid}, 64'd0);
    m_if.stall = 1'b0; m_if.in_valid = 1'b0; tick();
    chk("stall.v6", {63'd0, m_if.out_valid}, 64'd0);
    tick();
    chk("stall.v7", {63'd0, m_if.out_valid}, 64'd1);
    chk("stall.p7", {56'd0, m_if.out_prefix}, 64'hFF);
    tick();
    chk("stall.drop", {63'd0, m_if.out_valid}, 64'd0);

    // clr coinciding with a loading result
    m_if.in_valid = 1'b1; m_if.in_data = 8'h00; tick();
    m_if.in_valid = 1'b0; tick(); tick();
    chk("clr.pre", {63'd0, m_if.acc_any}, 64'd1);
    m_if.clr = 1'b1; tick(); m_if.clr = 1'b0;
    chk("clr.v0",   {63'd0, m_if.out_valid}, 64'd1);
    chk("clr.acc0", {63'd0, m_if.acc_any}, 64'd0);
    m_if.in_valid = 1'b1; m_if.in_data = 8'h04; tick();
    m_if.in_valid = 1'b0; tick(); tick();
    chk("clr.hold0", {63'd0, m_if.acc_any}, 64'd0);
    m_if.clr = 1'b1; tick(); m_if.clr = 1'b0;
    chk("clr.p1",   {56'd0, m_if.out_prefix}, 64'hFC);
    chk("clr.acc1", {63'd0, m_if.acc_any}, 64'd1);
    m_if.stall = 1'b1; m_if.clr = 1'b1; tick();
    chk("clrstall.acc",  {63'd0, m_if.acc_any}, 64'd0);
    chk("clrstall.hold", {63'd0, m_if.out_valid}, 64'd1);
    chk("clrstall.p",    {56'd0, m_if.out_prefix}, 64'hFC);
    m_if.stall = 1'b0; m_if.clr = 1'b0; tick();

    // Reset with a full pipeline discards everything in flight
    m_if.in_valid = 1'b1; m_if.in_data = 8'hFF;
    repeat (4) tick();
    chk("fill.v", {63'd0, m_if.out_valid}, 64'd1);
    rst = 1'b1; m_if.in_valid = 1'b0; tick(); rst = 1'b0;
    chk("mrst.valid",  {63'd0, m_if.out_valid}, 64'd0);
    chk("mrst.prefix", {56'd0, m_if.out_prefix}, 64'd0);
    chk("mrst.any",    {63'd0, m_if.out_any}, 64'd0);
    chk("mrst.acc",    {63'd0, m_if.acc_any}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst.flush", {63'd0, m_if.out_valid}, 64'd0);
    end
    m_if.in_valid = 1'b1; m_if.in_data = 8'h02; tick();
    m_if.in_valid = 1'b0; tick(); tick();
    chk("post.early", {63'd0, m_if.out_valid}, 64'd0);
    tick();
    chk("post.valid",  {63'd0, m_if.out_valid}, 64'd1);
    chk("post.prefix", {56'd0, m_if.out_prefix}, 64'hFE);
    chk("post.acc",    {63'd0, m_if.acc_any}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
